lsu_ctrl: RTL

Load/store initiator between the pipeline's MEM stage and the data memory port. Accepts one load or store request at a time over a valid/ready handshake and validates alignment, address range and access type. Legal requests are driven onto the data memory port (write enable, access type, address, write data, PC) for exactly one cycle, and load data is captured. Returns a registered response, with an error flag in place of any memory access for illegal requests.

---
 rtl/lsu_ctrl_pkg.sv | 21 ++
 rtl/lsu_ctrl_check.sv | 35 +++
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store initiator: data memory access type codes
// (also used by the data memory) and the controller state codes.
package lsu_ctrl_pkg;

    localparam logic [2:0] DM_w  = 3'd0;
    localparam logic [2:0] DM_h  = 3'd1;
    localparam logic [2:0] DM_hu = 3'd2;
    localparam logic [2:0] DM_b  = 3'd3;
    localparam logic [2:0] DM_bu = 3'd4;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic type_is_legal(input logic [2:0] acc_type);
        return acc_type <= DM_bu;
    endfunction

endpackage

// File: rtl/lsu_ctrl_check.sv
// Combinational request validator: alignment, address window, access type and
// store/type compatibility. Any violation raises err.
module lsu_check
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        we,
    input  logic [2:0]  acc_type,
    input  logic [31:0] addr,
    output logic        err
);

    logic misaligned;
    logic out_of_range;
    logic bad_type;
    logic bad_store;

    always_comb begin
        misaligned = 1'b0;
        case (acc_type)
            DM_w:         misaligned = (addr[1:0] != 2'b00);
            DM_h, DM_hu:  misaligned = addr[0];
            default:      misaligned = 1'b0;
        endcase
    end

    assign out_of_range = (addr >= ADDR_LIMIT);
    assign bad_type     = !type_is_legal(acc_type);
    // Unsigned variants only make sense for loads.
    assign bad_store    = we && ((acc_type == DM_hu) || (acc_type == DM_bu));

    assign err = misaligned | out_of_range | bad_type | bad_store;

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator between MEM stage and data memory: one request at a time,
// a single-cycle memory access for legal requests, and a registered response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        dm_wr,
    output logic [2:0]  dm_type,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] rsp_badaddr
);

    lsu_state_e  state_reg;
    logic        req_ready_reg;
    logic        dm_wr_reg;
    logic [2:0]  dm_type_reg;
    logic [31:0] dm_addr_reg;
    logic [31:0] dm_wd_reg;
    logic [31:0] dm_pc_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_badaddr_reg;
    logic        chk_err;

    lsu_check #(
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_check (
        .we       (req_we),
        .acc_type (req_type),
        .addr     (req_addr),
        .err      (chk_err)
    );

    // The dm_* registers double as the captured request; they are only non-zero
    // during ACCESS, so the memory port is quiet in every other state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= LSU_IDLE;
            req_ready_reg   <= 1'b1;
            dm_wr_reg       <= 1'b0;
            dm_type_reg     <= '0;
            dm_addr_reg     <= '0;
            dm_wd_reg       <= '0;
            dm_pc_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_badaddr_reg <= '0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_ready_reg <= 1'b0;
                        if (chk_err) begin
                            state_reg       <= LSU_RESP;
                            rsp_valid_reg   <= 1'b1;
                            rsp_err_reg     <= 1'b1;
                            rsp_badaddr_reg <= req_addr;
                            rsp_data_reg    <= '0;
                        end else begin
                            state_reg   <= LSU_ACCESS;
                            dm_wr_reg   <= req_we;
                            dm_type_reg <= req_type;
                            dm_addr_reg <= req_addr;
                            dm_wd_reg   <= req_we ? req_wdata : 32'd0;
                            dm_pc_reg   <= req_pc;
                        end
                    end
                end
                LSU_ACCESS: begin
                    state_reg     <= LSU_RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_data_reg  <= dm_wr_reg ? 32'd0 : dm_rdata;
                    dm_wr_reg     <= 1'b0;
                    dm_type_reg   <= '0;
                    dm_addr_reg   <= '0;
                    dm_wd_reg     <= '0;
                    dm_pc_reg     <= '0;
                end
                LSU_RESP: begin
                    if (rsp_ready) begin
                        state_reg       <= LSU_IDLE;
                        req_ready_reg   <= 1'b1;
                        rsp_valid_reg   <= 1'b0;
                        rsp_data_reg    <= '0;
                        rsp_err_reg     <= 1'b0;
                        rsp_badaddr_reg <= '0;
                    end
                end
                default: begin
                    state_reg       <= LSU_IDLE;
                    req_ready_reg   <= 1'b1;
                    dm_wr_reg       <= 1'b0;
                    dm_type_reg     <= '0;
                    dm_addr_reg     <= '0;
                    dm_wd_reg       <= '0;
                    dm_pc_reg       <= '0;
                    rsp_valid_reg   <= 1'b0;
                    rsp_data_reg    <= '0;
                    rsp_err_reg     <= 1'b0;
                    rsp_badaddr_reg <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign dm_wr       = dm_wr_reg;
    assign dm_type     = dm_type_reg;
    assign dm_addr     = dm_addr_reg;
    assign dm_wd       = dm_wd_reg;
    assign dm_pc       = dm_pc_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_badaddr = rsp_badaddr_reg;

endmodule
